// File: rtl/obstacle_gen.sv
// Obstacle generator: twenty scrolling obstacle slots with LFSR-driven spawn
// heights and intervals, retirement scoring and a spawn-count speed ramp.
module obstacle_gen #(
    parameter int SPAWN_X      = 639,
    parameter int Y_MIN        = 160,
    parameter int FIRST_DELAY  = 60,
    parameter int MIN_GAP      = 24,
    parameter int SPEED_INIT   = 2,
    parameter int SPEED_MAX    = 8,
    parameter int LEVEL_SPAWNS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   gamemode,
    output logic [199:0] obstacle_x,
    output logic [179:0] obstacle_y,
    output logic [13:0]  score,
    output logic         passed
);

    localparam int          NSLOT         = 20;
    localparam logic [9:0]  X_NONE        = 10'h3FF;
    localparam logic [1:0]  MODE_IDLE     = 2'b00;
    localparam logic [1:0]  MODE_PLAY     = 2'b01;
    localparam logic [9:0]  SPAWN_X_V     = 10'(SPAWN_X);
    localparam logic [8:0]  Y_MIN_V       = 9'(Y_MIN);
    localparam logic [15:0] FIRST_DELAY_V = 16'(FIRST_DELAY);
    localparam logic [15:0] MIN_GAP_V     = 16'(MIN_GAP);
    localparam logic [3:0]  SPEED_INIT_V  = 4'(SPEED_INIT);
    localparam logic [3:0]  SPEED_MAX_V   = 4'(SPEED_MAX);
    localparam logic [15:0] LEVEL_V       = 16'(LEVEL_SPAWNS);
    localparam logic [13:0] SCORE_MAX     = 14'h3FFF;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

    // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [13:0] score_add(input logic [13:0] s, input logic [4:0] n);
        logic [14:0] sum;
        sum = {1'b0, s} + {10'd0, n};
        if (sum > {1'b0, SCORE_MAX}) begin
            return SCORE_MAX;
        end else begin
            return sum[13:0];
        end
    endfunction

    logic [9:0]  slot_x_r      [NSLOT];
    logic [8:0]  slot_y_r      [NSLOT];
    logic [9:0]  slot_x_nxt_s  [NSLOT];
    logic [8:0]  slot_y_nxt_s  [NSLOT];
    logic [15:0] lfsr_r;
    logic [15:0] spawn_cnt_r;
    logic [15:0] spawn_cnt_nxt_s;
    logic [15:0] spawn_total_r;
    logic [15:0] spawn_total_nxt_s;
    logic [15:0] total_inc_s;
    logic [3:0]  speed_r;
    logic [3:0]  speed_nxt_s;
    logic [13:0] score_r;
    logic [13:0] score_nxt_s;
    logic        passed_r;
    logic        passed_nxt_s;
    logic [4:0]  retire_cnt_s;
    logic [4:0]  spawn_idx_s;
    logic        free_hit_s;

    // Pseudo-random source; runs in every mode so idle time shapes the pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Lowest-index slot that was inactive before this edge (retiring slots excluded).
    always_comb begin
        free_hit_s  = 1'b0;
        spawn_idx_s = 5'd0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (slot_x_r[i] == X_NONE) begin
                free_hit_s  = 1'b1;
                spawn_idx_s = 5'(i);
            end else begin
                free_hit_s  = free_hit_s;
            end
        end
    end

    // Next-state for slots, spawn timer, level, score and the pass pulse.
    always_comb begin
        slot_x_nxt_s      = slot_x_r;
        slot_y_nxt_s      = slot_y_r;
        spawn_cnt_nxt_s   = spawn_cnt_r;
        spawn_total_nxt_s = spawn_total_r;
        total_inc_s       = spawn_total_r + 16'd1;
        speed_nxt_s       = speed_r;
        score_nxt_s       = score_r;
        passed_nxt_s      = 1'b0;
        retire_cnt_s      = 5'd0;

        case (gamemode)
            MODE_IDLE: begin
                for (int i = 0; i < NSLOT; i++) begin
                    slot_x_nxt_s[i] = X_NONE;
                    slot_y_nxt_s[i] = 9'd0;
                end
                spawn_cnt_nxt_s   = FIRST_DELAY_V;
                spawn_total_nxt_s = 16'd0;
                speed_nxt_s       = SPEED_INIT_V;
                score_nxt_s       = 14'd0;
            end

            MODE_PLAY: begin
                // Compare before subtracting so x can never wrap below zero.
                for (int i = 0; i < NSLOT; i++) begin
                    if (slot_x_r[i] == X_NONE) begin
                        slot_x_nxt_s[i] = X_NONE;
                    end else if (slot_x_r[i] < {6'd0, speed_r}) begin
                        slot_x_nxt_s[i] = X_NONE;
                        slot_y_nxt_s[i] = 9'd0;
                        retire_cnt_s    = retire_cnt_s + 5'd1;
                    end else begin
                        slot_x_nxt_s[i] = slot_x_r[i] - {6'd0, speed_r};
                    end
                end
                score_nxt_s  = score_add(score_r, retire_cnt_s);
                passed_nxt_s = (retire_cnt_s != 5'd0);

                if (spawn_cnt_r != 16'd0) begin
                    spawn_cnt_nxt_s = spawn_cnt_r - 16'd1;
                end else if (free_hit_s) begin
                    slot_x_nxt_s[spawn_idx_s] = SPAWN_X_V;
                    slot_y_nxt_s[spawn_idx_s] = Y_MIN_V + {1'b0, lfsr_r[7:0]};
                    spawn_cnt_nxt_s           = MIN_GAP_V + {12'd0, lfsr_r[3:0]};
                    spawn_total_nxt_s         = total_inc_s;
                    if (((total_inc_s % LEVEL_V) == 16'd0) && (speed_r < SPEED_MAX_V)) begin
                        speed_nxt_s = speed_r + 4'd1;
                    end else begin
                        speed_nxt_s = speed_r;
                    end
                end else begin
                    // Buffer full: keep retrying every edge.
                    spawn_cnt_nxt_s = 16'd0;
                end
            end

            default: begin
                passed_nxt_s = 1'b0;
            end
        endcase
    end

    // Game state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_x_r      <= '{default: X_NONE};
            slot_y_r      <= '{default: 9'd0};
            spawn_cnt_r   <= FIRST_DELAY_V;
            spawn_total_r <= 16'd0;
            speed_r       <= SPEED_INIT_V;
            score_r       <= 14'd0;
            passed_r      <= 1'b0;
        end else begin
            slot_x_r      <= slot_x_nxt_s;
            slot_y_r      <= slot_y_nxt_s;
            spawn_cnt_r   <= spawn_cnt_nxt_s;
            spawn_total_r <= spawn_total_nxt_s;
            speed_r       <= speed_nxt_s;
            score_r       <= score_nxt_s;
            passed_r      <= passed_nxt_s;
        end
    end

    // Pack slot registers onto the shared buses.
    always_comb begin
        obstacle_x = '0;
        obstacle_y = '0;
        for (int i = 0; i < NSLOT; i++) begin
            obstacle_x[10*i +: 10] = slot_x_r[i];
            obstacle_y[9*i +: 9]   = slot_y_r[i];
        end
    end

    assign score  = score_r;
    assign passed = passed_r;

endmodule

// File: tb/tb_obstacle_gen.sv
// Directed bench for obstacle_gen: a default instance (level ramp), a
// constant-speed instance (scroll/retire/pause) and a MIN_GAP=0 instance (full buffer).
module tb_obstacle_gen;

    logic         clk;
    logic         rst;
    logic [1:0]   gamemode;
    logic [199:0] xa, xs, xb;
    logic [179:0] ya, ys, yb;
    logic [13:0]  sa, ss, sb;
    logic         pa, ps, pb;

    int total = 0;
    int bad   = 0;

    obstacle_gen dut_a (
        .clk(clk), .rst(rst), .gamemode(gamemode),
        .obstacle_x(xa), .obstacle_y(ya), .score(sa), .passed(pa)
    );

    obstacle_gen #(.LEVEL_SPAWNS(60000)) dut_s (
        .clk(clk), .rst(rst), .gamemode(gamemode),
        .obstacle_x(xs), .obstacle_y(ys), .score(ss), .passed(ps)
    );

    obstacle_gen #(.MIN_GAP(0), .SPEED_INIT(1), .LEVEL_SPAWNS(60000)) dut_b (
        .clk(clk), .rst(rst), .gamemode(gamemode),
        .obstacle_x(xb), .obstacle_y(yb), .score(sb), .passed(pb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] sx(input logic [199:0] bus, input int i);
        return bus[10*i +: 10];
    endfunction

    function automatic logic [8:0] sy(input logic [179:0] bus, input int i);
        return bus[9*i +: 9];
    endfunction

    function automatic int count_val(input logic [199:0] bus, input logic [9:0] v);
        int n = 0;
        for (int i = 0; i < 20; i++) if (bus[10*i +: 10] == v) n++;
        return n;
    endfunction

    function automatic int find_val(input logic [199:0] bus, input logic [9:0] v);
        int r = -1;
        for (int i = 19; i >= 0; i--) if (bus[10*i +: 10] == v) r = i;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: LFSR, playing-edge count and spawn schedule (default spawn params).
    logic [15:0] lfsr_m, lf_used_m;
    int          cnt_m, p_m, nsp_m;
    logic        spawn_ev_m;
    logic [8:0]  spawn_y_m, first_y_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_m     <= 16'hACE1;
            lf_used_m  <= 16'h0000;
            cnt_m      <= 60;
            p_m        <= 0;
            nsp_m      <= 0;
            spawn_ev_m <= 1'b0;
            spawn_y_m  <= 9'd0;
            first_y_m  <= 9'd0;
        end else begin
            lfsr_m     <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
            lf_used_m  <= lfsr_m;
            spawn_ev_m <= 1'b0;
            if (gamemode == 2'b00) begin
                cnt_m <= 60;
                p_m   <= 0;
                nsp_m <= 0;
            end else if (gamemode == 2'b01) begin
                p_m <= p_m + 1;
                if (cnt_m != 0) begin
                    cnt_m <= cnt_m - 1;
                end else begin
                    cnt_m      <= 24 + int'(lfsr_m[3:0]);
                    nsp_m      <= nsp_m + 1;
                    spawn_ev_m <= 1'b1;
                    spawn_y_m  <= 9'd160 + {1'b0, lfsr_m[7:0]};
                    if (nsp_m == 0) first_y_m <= 9'd160 + {1'b0, lfsr_m[7:0]};
                end
            end
        end
    end

    // Background checks: every spawn's y and next-edge step, plus full-buffer events.
    initial begin : bg
        int   idx_a, idx_s, pend_p, exp_a, spd;
        logic pend;
        pend = 1'b0; idx_a = 0; idx_s = 0; pend_p = 0; exp_a = 0;
        forever begin
            @(negedge clk);
            if (rst || p_m == 0) begin
                pend = 1'b0;
            end else begin
                if (pend && p_m == pend_p + 1) begin
                    chk("step_after_spawn_a", int'(sx(xa, idx_a)), exp_a);
                    chk("step_after_spawn_s", int'(sx(xs, idx_s)), 637);
                    pend = 1'b0;
                end
                if (spawn_ev_m) begin
                    chk("spawn_one_new_a", count_val(xa, 10'd639), 1);
                    chk("spawn_one_new_s", count_val(xs, 10'd639), 1);
                    idx_a = find_val(xa, 10'd639);
                    idx_s = find_val(xs, 10'd639);
                    if (idx_a < 0) idx_a = 0;
                    if (idx_s < 0) idx_s = 0;
                    chk("spawn_y_a", int'(sy(ya, idx_a)), int'(spawn_y_m));
                    chk("spawn_y_s", int'(sy(ys, idx_s)), int'(spawn_y_m));
                    spd = 2 + nsp_m / 8;
                    if (spd > 8) spd = 8;
                    exp_a  = 639 - spd;
                    pend   = 1'b1;
                    pend_p = p_m;
                end
                if (p_m == 700 && gamemode == 2'b01) begin
                    chk("b_full_700", 20 - count_val(xb, 10'h3FF), 20);
                    chk("b_x0_700", int'(sx(xb, 0)), 0);
                end
                if (p_m == 701 && gamemode == 2'b01) begin
                    chk("b_x0_retired", int'(sx(xb, 0)), 1023);
                    chk("b_active_701", 20 - count_val(xb, 10'h3FF), 19);
                    chk("b_passed_701", int'(pb), 1);
                    chk("b_score_701", int'(sb), 1);
                end
                if (p_m == 702 && gamemode == 2'b01) begin
                    chk("b_x0_reuse", int'(sx(xb, 0)), 639);
                    chk("b_y0_reuse", int'(sy(yb, 0)), 160 + int'(lf_used_m[7:0]));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0] gm;
        int         n;
        logic       chk_x;
        logic [9:0] x0;
        logic       passed;
        int         score;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [199:0] snap_x;
        logic [179:0] snap_y;
        logic [13:0]  snap_s;
        int           exp_y;

        tbl[0]  = '{2'b00,   3, 1'b1, 10'h3FF, 1'b0, 0};
        tbl[1]  = '{2'b01,  60, 1'b1, 10'h3FF, 1'b0, 0};
        tbl[2]  = '{2'b01,   1, 1'b1, 10'd639, 1'b0, 0};
        tbl[3]  = '{2'b01,   1, 1'b1, 10'd637, 1'b0, 0};
        tbl[4]  = '{2'b01,  88, 1'b1, 10'd461, 1'b0, 0};
        tbl[5]  = '{2'b10,   1, 1'b1, 10'd461, 1'b0, 0};
        tbl[6]  = '{2'b10,   9, 1'b1, 10'd461, 1'b0, 0};
        tbl[7]  = '{2'b01,   1, 1'b1, 10'd459, 1'b0, 0};
        tbl[8]  = '{2'b01, 229, 1'b1, 10'd1,   1'b0, 0};
        tbl[9]  = '{2'b01,   1, 1'b1, 10'h3FF, 1'b1, 1};
        tbl[10] = '{2'b01,   1, 1'b0, 10'h3FF, 1'b0, 1};

        rst = 1'b1;
        gamemode = 2'b00;
        @(negedge clk);
        chk("reset_x_all", count_val(xa, 10'h3FF), 20);
        chk("reset_y_all", int'(ya == '0), 1);
        chk("reset_score", int'(sa), 0);
        chk("reset_passed", int'(pa), 0);
        rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            gamemode = tbl[k].gm;
            repeat (tbl[k].n) @(negedge clk);
            if (tbl[k].chk_x) begin
                exp_y = (tbl[k].x0 == 10'h3FF) ? 0 : int'(first_y_m);
                chk($sformatf("vec%0d_x0", k), int'(sx(xs, 0)), int'(tbl[k].x0));
                chk($sformatf("vec%0d_y0", k), int'(sy(ys, 0)), exp_y);
            end
            chk($sformatf("vec%0d_passed", k), int'(ps), int'(tbl[k].passed));
            chk($sformatf("vec%0d_score", k), int'(ss), tbl[k].score);
        end

        // Long run: level ramp up to the cap and the full-buffer instance.
        while ((nsp_m < 57 || p_m < 710) && p_m < 3000) @(negedge clk);
        chk("long_run_bound", int'(nsp_m >= 57), 1);
        repeat (2) @(negedge clk);

        // Game over holds everything.
        gamemode = 2'b11;
        snap_x = xa; snap_y = ya; snap_s = sa;
        chk("gameover_had_active", int'(count_val(xa, 10'h3FF) < 20), 1);
        repeat (6) begin
            @(negedge clk);
            chk("gameover_x_hold", int'(xa == snap_x), 1);
            chk("gameover_y_hold", int'(ya == snap_y), 1);
            chk("gameover_score_hold", int'(sa), int'(snap_s));
            chk("gameover_passed", int'(pa), 0);
        end

        gamemode = 2'b00;
        @(negedge clk);
        chk("idle_x_clear", count_val(xa, 10'h3FF), 20);
        chk("idle_y_clear", int'(ya == '0), 1);
        chk("idle_score_clear", int'(sa), 0);
        chk("idle_passed", int'(pa), 0);

        // Reset mid-play with five slots active.
        gamemode = 2'b01;
        while (nsp_m < 5 && p_m < 400) @(negedge clk);
        chk("pre_reset_active", 20 - count_val(xa, 10'h3FF), 5);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_x", count_val(xa, 10'h3FF), 20);
        chk("async_reset_y", int'(ya == '0), 1);
        chk("async_reset_score", int'(sa), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("post_reset_edge60", count_val(xa, 10'h3FF), 20);
        @(negedge clk);
        chk("post_reset_edge61", int'(sx(xa, 0)), 639);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
